hamming_serial_rx: RTL and testbench
====================================

// Module: hamming_serial_rx
// PURPOSE
//  Receiving end of the Hamming(12,8) codeword link. Deserialises a bit-serial 12-bit
//  codeword, computes the 4-bit syndrome, corrects any single-bit error and delivers
//  the 8-bit payload through a one-entry valid/ready output buffer. It sits between
//  the link and the display slaves, in place of the parallel corrector.
// PARAMETERS
//  CW_BITS   12  codeword length. Fixed: any other value is a compile-time error.
//  DATA_BITS 8   payload width. Fixed: any other value is a compile-time error.
// PORTS
//  clk              in   1  clock, rising edge
//  reset            in   1  reset, asynchronous, active-high
//  rx_bit           in   1  serial codeword bit; sampled only when rx_valid=1
//  rx_valid         in   1  rx_bit strobe, one bit per strobed cycle
//  rx_sof           in   1  start of frame; qualified by rx_valid; marks codeword position 1
//  data_out         out  8  corrected payload; stable while data_valid=1
//  data_valid       out  1  payload available
//  data_ready       in   1  consumer accepts; transfer when data_valid & data_ready
//  syndrome         out  4  syndrome of the held frame (0 = clean)
//  err_corrected    out  1  held frame had syndrome 1..12; one bit was flipped
//  err_uncorrectable out 1  held frame had syndrome 13..15; data_out is the raw payload
//  overrun          out  1  one-cycle pulse: a completed frame was dropped
//  frame_abort      out  1  one-cycle pulse: rx_sof arrived mid-frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, bit count 0, shift register 0. The whole block is
//   cleared, including any partial frame or a held output.
//  Codeword map: position p (1..12) is cw[p-1]. Parity bits sit at positions 1, 2, 4, 8.
//   Data bits: d0..d7 -> positions 3, 5, 6, 7, 9, 10, 11, 12.
//  Serial order: position 1 first, position 12 last. The position-1 bit arrives with rx_sof=1.
//  Syndrome bit k = XOR of cw[p-1] over all p with bit k of p set (k = 0..3).
//  FSM IDLE: on rx_valid & rx_sof, capture position 1, set count=1, go to SHIFT.
//   rx_valid without rx_sof is ignored.
//  FSM SHIFT: each rx_valid captures position count+1 and increments count.
//   When the bit at position 12 is captured, go to DECODE.
//   rx_valid & rx_sof in SHIFT pulses frame_abort, captures position 1, sets count=1
//   and stays in SHIFT.
//  FSM DECODE (1 cycle): register the syndrome and the corrected payload.
//   Syndrome 1..12: flip position s. Syndrome 0 or 13..15: no flip.
//   Write the output buffer and go to IDLE. rx_valid in DECODE is ignored.
//  Latency: data_valid rises 2 clock edges after the edge that captures position 12.
//  Output buffer: data_valid stays high until the data_valid & data_ready edge, then
//   clears, unless DECODE writes on that same edge; in that case data_valid stays 1 and
//   the new frame is loaded. data_out, syndrome and the err_* flags change only on a load.
//  Full buffer: if DECODE finds data_valid=1 and data_ready=0, the new frame is dropped,
//   overrun pulses and the held frame is unchanged.
//  This is single-error correction only. A double error with syndrome <= 12 miscorrects
//   and sets err_corrected. This is accepted behaviour.
//  Bit count: 4 bits, range 0..11. It never wraps past 12.
// STRUCTURE
//  hamming_pkg: CW_BITS and DATA_BITS; parity position constants;
//   DATA_POS[0:7] = {3,5,6,7,9,10,11,12}; functions hamming_syndrome() and extract_data().
//  Sub-module hamming_syndrome_calc: combinational cw[11:0] -> syndrome[3:0] plus
//   corrected payload. It is shared with the encoder self-check.
//  This block: FSM, bit counter, shift register, output buffer.
// TESTING
//  Clean 0xA5, codeword positions 1..12 = 1,1,1,0,0,1,0,0,0,1,0,1, data_ready=1
//   -> data_out=A5, syndrome=0, both err flags 0, data_valid high 2 edges after bit 12.
//  Same codeword with position 6 inverted -> data_out=A5, syndrome=6, err_corrected=1.
//  0xA5 with positions 4 and 9 inverted -> syndrome=13, err_uncorrectable=1, data_out=B5.
//  0xA5 with positions 1 and 2 inverted -> syndrome=3, err_corrected=1, data_out=A4
//   (documented miscorrection).
//  data_ready=0, send two frames back to back -> first frame held, overrun pulses once.
//   Then data_ready=1 -> first frame transfers and data_valid=0.
//  rx_sof after 7 bits -> frame_abort pulses. A following full 0xA5 frame -> data_out=A5.
//  Assert reset after 5 bits -> all outputs 0 and no data_valid until a new rx_sof frame.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(12,8) constants, decode result type and syndrome/extract helpers
package hamming_pkg;

    localparam int CW_BITS   = 12;
    localparam int DATA_BITS = 8;

    localparam int PARITY_POS [0:3] = '{1, 2, 4, 8};
    localparam int DATA_POS   [0:7] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef struct packed {
        logic                 uncorrectable;
        logic                 corrected;
        logic [3:0]           syndrome;
        logic [DATA_BITS-1:0] data;
    } dec_result_t;

    // XOR of the positions of all set bits equals the per-bit parity-group syndrome.
    function automatic logic [3:0] hamming_syndrome(input logic [CW_BITS-1:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p <= CW_BITS; p++) begin
            if (cw[p-1]) s = s ^ p[3:0];
        end
        return s;
    endfunction

    function automatic logic [DATA_BITS-1:0] extract_data(input logic [CW_BITS-1:0] cw);
        logic [DATA_BITS-1:0] d;
        for (int i = 0; i < DATA_BITS; i++) begin
            d[i] = cw[DATA_POS[i]-1];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_serial_rx_if.sv
// rtl/hamming_serial_rx_if.sv - valid/ready payload channel carrying the corrected frame and its status
interface hamming_serial_rx_if;
    import hamming_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic [3:0]           syndrome;
    logic                 err_corrected;
    logic                 err_uncorrectable;

    modport master (
        output data_out, data_valid, syndrome, err_corrected, err_uncorrectable,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, syndrome, err_corrected, err_uncorrectable,
        output data_ready
    );
endinterface

// File: rtl/hamming_syndrome_calc.sv
// rtl/hamming_syndrome_calc.sv - combinational syndrome and single-bit-corrected payload of a 12-bit codeword
module hamming_syndrome_calc
    import hamming_pkg::*;
(
    input  logic [CW_BITS-1:0]   cw,
    output logic [3:0]           syndrome,
    output logic [DATA_BITS-1:0] data
);

    logic [CW_BITS-1:0] fixed_cw;

    always_comb begin
        syndrome = hamming_syndrome(cw);
        fixed_cw = cw;
        // Syndromes 13..15 point outside the codeword: pass the raw payload through.
        if (syndrome >= 4'd1 && syndrome <= 4'd12) begin
            fixed_cw[syndrome - 4'd1] = ~cw[syndrome - 4'd1];
        end
        data = extract_data(fixed_cw);
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - bit-serial Hamming(12,8) receiver with single-error correction and one-entry output buffer
module hamming_serial_rx #(
    parameter int CW_BITS   = 12,
    parameter int DATA_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_bit,
    input  logic                       rx_valid,
    input  logic                       rx_sof,
    hamming_serial_rx_if.master        rx_out,
    output logic                       overrun,
    output logic                       frame_abort
);
    import hamming_pkg::*;

    if (CW_BITS != 12 || DATA_BITS != 8) begin : g_bad_param
        $error("hamming_serial_rx supports only CW_BITS=12, DATA_BITS=8");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    logic [1:0]          state;
    logic [3:0]          bit_cnt;
    logic [11:0]         shift_reg;
    logic [3:0]          calc_syn;
    logic [7:0]          calc_data;
    dec_result_t         dec_comb;
    dec_result_t         dec_q;
    logic                dec_pend;

    hamming_syndrome_calc u_calc (
        .cw       (shift_reg),
        .syndrome (calc_syn),
        .data     (calc_data)
    );

    always_comb begin
        dec_comb.data          = calc_data;
        dec_comb.syndrome      = calc_syn;
        dec_comb.corrected     = (calc_syn >= 4'd1) && (calc_syn <= 4'd12);
        dec_comb.uncorrectable = (calc_syn >= 4'd13);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 12'd0;
            dec_q       <= '0;
            dec_pend    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            dec_pend    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_sof) begin
                        shift_reg <= {11'd0, rx_bit};
                        bit_cnt   <= 4'd1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rx_valid && rx_sof) begin
                        frame_abort <= 1'b1;
                        shift_reg   <= {11'd0, rx_bit};
                        bit_cnt     <= 4'd1;
                    end else if (rx_valid) begin
                        shift_reg[bit_cnt] <= rx_bit;
                        if (bit_cnt == 4'd11) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_DECODE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_DECODE: begin
                    dec_q    <= dec_comb;
                    dec_pend <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A pending result lands in the buffer unless the consumer is still holding off a full one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_out.data_out          <= '0;
            rx_out.data_valid        <= 1'b0;
            rx_out.syndrome          <= 4'd0;
            rx_out.err_corrected     <= 1'b0;
            rx_out.err_uncorrectable <= 1'b0;
            overrun                  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (dec_pend && rx_out.data_valid && !rx_out.data_ready) begin
                overrun <= 1'b1;
            end else if (dec_pend) begin
                rx_out.data_out          <= dec_q.data;
                rx_out.syndrome          <= dec_q.syndrome;
                rx_out.err_corrected     <= dec_q.corrected;
                rx_out.err_uncorrectable <= dec_q.uncorrectable;
                rx_out.data_valid        <= 1'b1;
            end else if (rx_out.data_valid && rx_out.data_ready) begin
                rx_out.data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb/tb_hamming_serial_rx.sv - self-checking bench for hamming_serial_rx against a positional Hamming model
module tb_hamming_serial_rx;

    logic clk = 1'b0;
    logic reset;
    logic rx_bit, rx_valid, rx_sof;
    logic overrun, frame_abort;

    hamming_serial_rx_if bus ();

    hamming_serial_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx_bit      (rx_bit),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_out      (bus),
        .overrun     (overrun),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    int ab_cnt   = 0;
    logic [13:0] xfer_q [$];
    logic [13:0] exp_q  [$];

    always @(negedge clk) begin
        if (overrun === 1'b1) ov_cnt++;
        if (frame_abort === 1'b1) ab_cnt++;
        if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1)
            xfer_q.push_back({bus.err_uncorrectable, bus.err_corrected, bus.syndrome, bus.data_out});
    end

    function automatic logic [11:0] m_encode(input logic [7:0] d);
        int dp [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [11:0] cw = 12'd0;
        logic par;
        for (int i = 0; i < 8; i++) cw[dp[i]-1] = d[i];
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 12; p++)
                if (((p >> k) & 1) == 1 && p != (1 << k)) par ^= cw[p-1];
            cw[(1 << k) - 1] = par;
        end
        return cw;
    endfunction

    // Result packed as {uncorrectable, corrected, syndrome[3:0], data[7:0]}.
    function automatic logic [13:0] m_decode(input logic [11:0] cw_in);
        int dp [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [11:0] cw = cw_in;
        int s = 0;
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            int b = 0;
            for (int p = 1; p <= 12; p++)
                if (((p >> k) & 1) == 1) b ^= int'(cw[p-1]);
            s += b << k;
        end
        if (s >= 1 && s <= 12) cw[s-1] = ~cw[s-1];
        for (int i = 0; i < 8; i++) d[i] = cw[dp[i]-1];
        return {s >= 13, s >= 1 && s <= 12, 4'(s), d};
    endfunction

    task automatic send_bits(input logic [11:0] cw, input int n, input bit sof_en);
        for (int p = 1; p <= n; p++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_bit   = cw[p-1];
            rx_sof   = sof_en && (p == 1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_bit   = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] cw);
        send_bits(cw, 12, 1'b1);
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (bus.data_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_bit = 0; rx_valid = 0; rx_sof = 0; bus.data_ready = 1'b0;
        idle(3);
        n_checks++;
        if ({bus.data_valid, bus.data_out, bus.syndrome, bus.err_corrected, bus.err_uncorrectable, overrun, frame_abort} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dv=%b d=%h s=%0d ec=%b eu=%b ov=%b ab=%b, expected all 0",
                     bus.data_valid, bus.data_out, bus.syndrome, bus.err_corrected, bus.err_uncorrectable, overrun, frame_abort);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_clean_a5;
        int c;
        bus.data_ready = 1'b1;
        send_frame(12'b1010_0010_0111);
        wait_valid(c);
        n_checks++;
        if (c !== 2) begin n_fail++; $display("FAIL clean_latency: got %0d cycles, expected 2", c); end
        n_checks++;
        if ({bus.data_out, bus.syndrome, bus.err_corrected, bus.err_uncorrectable} !== {8'hA5, 4'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL clean_a5: got d=%h s=%0d ec=%b eu=%b, expected d=a5 s=0 ec=0 eu=0",
                     bus.data_out, bus.syndrome, bus.err_corrected, bus.err_uncorrectable);
        end
        @(negedge clk);
        n_checks++;
        if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drain: got dv=%b, expected 0", bus.data_valid); end
    endtask

    task automatic test_known_errors;
        logic [11:0] cw_list [3] = '{12'hA27 ^ 12'h020, 12'hA27 ^ 12'h108, 12'hA27 ^ 12'h003};
        logic [13:0] exp_list [3] = '{{2'b01, 4'd6, 8'hA5}, {2'b10, 4'd13, 8'hB5}, {2'b01, 4'd3, 8'hA4}};
        int c;
        bus.data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_frame(cw_list[i]);
            wait_valid(c);
            n_checks++;
            if (c !== 2 || {bus.err_uncorrectable, bus.err_corrected, bus.syndrome, bus.data_out} !== exp_list[i]) begin
                n_fail++;
                $display("FAIL known_err%0d: got lat=%0d eu=%b ec=%b s=%0d d=%h, expected lat=2 %h",
                         i, c, bus.err_uncorrectable, bus.err_corrected, bus.syndrome, bus.data_out, exp_list[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_random_single;
        int c, e;
        logic [7:0] d;
        logic [11:0] cw;
        bus.data_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d  = 8'($urandom);
            e  = $urandom_range(0, 12);
            cw = m_encode(d);
            if (e != 0) cw[e-1] = ~cw[e-1];
            send_frame(cw);
            wait_valid(c);
            n_checks++;
            if (c !== 2 || bus.data_out !== d || bus.syndrome !== 4'(e) ||
                bus.err_corrected !== (e != 0) || bus.err_uncorrectable !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_single%0d: got lat=%0d d=%h s=%0d ec=%b eu=%b, expected lat=2 d=%h s=%0d ec=%b eu=0",
                         i, c, bus.data_out, bus.syndrome, bus.err_corrected, bus.err_uncorrectable, d, e, e != 0);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic [11:0] cw;
        int a, b;
        bus.data_ready = 1'b1;
        idle(3);
        xfer_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            cw = m_encode(8'($urandom));
            a  = $urandom_range(0, 12);
            b  = $urandom_range(1, 12);
            if (a != 0) cw[a-1] = ~cw[a-1];
            if (a != 0 && b != a) cw[b-1] = ~cw[b-1];
            exp_q.push_back(m_decode(cw));
            send_frame(cw);
        end
        idle(5);
        n_checks++;
        if (xfer_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d transfers, expected %0d", xfer_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (xfer_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d: got %h, expected %h", i, xfer_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overrun;
        logic [7:0] d2;
        d2 = 8'($urandom) ^ 8'h5A;
        bus.data_ready = 1'b0;
        ov_cnt = 0;
        send_frame(m_encode(8'hA5));
        send_frame(m_encode(d2));
        idle(6);
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5 || ov_cnt !== 1) begin
            n_fail++;
            $display("FAIL overrun_hold: got dv=%b d=%h overruns=%0d, expected dv=1 d=a5 overruns=1",
                     bus.data_valid, bus.data_out, ov_cnt);
        end
        bus.data_ready = 1'b1;
        idle(1);
        n_checks++;
        if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drain: got dv=%b, expected 0", bus.data_valid); end
    endtask

    task automatic test_abort;
        int c;
        bus.data_ready = 1'b1;
        ab_cnt = 0;
        send_bits(m_encode(8'($urandom)), 7, 1'b1);
        send_frame(m_encode(8'hA5));
        wait_valid(c);
        n_checks++;
        if (ab_cnt !== 1 || c !== 2 || bus.data_out !== 8'hA5 || bus.syndrome !== 4'd0) begin
            n_fail++;
            $display("FAIL abort: got aborts=%0d lat=%0d d=%h s=%0d, expected aborts=1 lat=2 d=a5 s=0",
                     ab_cnt, c, bus.data_out, bus.syndrome);
        end
        idle(2);
    endtask

    task automatic test_reset_midframe;
        int c;
        bus.data_ready = 1'b0;
        send_frame(m_encode(8'h3C));
        wait_valid(c);
        send_bits(m_encode(8'hA5), 5, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_valid, bus.data_out, bus.syndrome, bus.err_corrected, bus.err_uncorrectable, overrun, frame_abort} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got dv=%b d=%h s=%0d, expected all 0", bus.data_valid, bus.data_out, bus.syndrome);
        end
        reset = 1'b0;
        send_bits(m_encode(8'hA5), 12, 1'b0);
        idle(4);
        n_checks++;
        if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_nosof: got dv=%b, expected 0", bus.data_valid); end
        bus.data_ready = 1'b1;
        send_frame(m_encode(8'hA5));
        wait_valid(c);
        n_checks++;
        if (c !== 2 || bus.data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got lat=%0d d=%h, expected lat=2 d=a5", c, bus.data_out);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_clean_a5();
        test_known_errors();
        test_random_single();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
